// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: boot/load/exec/stop mode machine, fetch PC, execute-latency
// counter and per-register hold/advance/clear codes. PIPE_SEQ_PERF_EN adds stall/flush counters.
module pipe_sequencer #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     NSTAGE      = 3,
    parameter int unsigned     FLUSH_DEPTH = NSTAGE,
    parameter int unsigned     LAT_W       = 5,
    parameter int unsigned     BOOT_STALL  = 10000,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_done,
    input  logic                  aa_sent,
    input  logic [LAT_W-1:0]      wait_time,
    input  logic                  busy,
    input  logic                  jump_dec,
    input  logic [XLEN-1:0]       dec_npc,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic                  stop_req,
    input  logic                  resume,
    output logic [XLEN-1:0]       pc,
    output logic [1:0]            mode,
    output logic [2*NSTAGE-1:0]   stage_update,
    output logic                  advance,
    output logic                  exec_start,
    output logic [LAT_W-1:0]      lat
`ifdef PIPE_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_stall,
    output logic [31:0]           perf_flush
`endif
);

    localparam logic [1:0] MODE_BOOT = 2'd0;
    localparam logic [1:0] MODE_LOAD = 2'd1;
    localparam logic [1:0] MODE_EXEC = 2'd2;
    localparam logic [1:0] MODE_STOP = 2'd3;

    localparam logic [1:0] SU_HOLD = 2'b00;
    localparam logic [1:0] SU_ADV  = 2'b01;
    localparam logic [1:0] SU_CLR  = 2'b10;

    localparam int unsigned      BOOT_W  = 32;
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    logic [1:0]        mode_d;
    logic [BOOT_W-1:0] boot_cnt;
    logic [BOOT_W-1:0] boot_cnt_d;
    logic [XLEN-1:0]   pc_d;
    logic [LAT_W-1:0]  lat_d;
    logic              exec_start_d;
    logic              npc_stall;

    // Pipeline may move only when execute has waited long enough and fetch has a valid PC
    always_comb begin
        npc_stall = jump_dec && (lat == '0);
        advance   = (mode == MODE_EXEC) && !redirect && (lat >= wait_time)
                    && !busy && !npc_stall;
    end

    // Redirect clears only the youngest FLUSH_DEPTH registers; older ones keep their work
    always_comb begin
        stage_update = '0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            if (mode != MODE_EXEC) begin
                stage_update[2*i +: 2] = SU_CLR;
            end else if (redirect) begin
                stage_update[2*i +: 2] = (i < FLUSH_DEPTH) ? SU_CLR : SU_HOLD;
            end else if (advance) begin
                stage_update[2*i +: 2] = SU_ADV;
            end else begin
                stage_update[2*i +: 2] = SU_HOLD;
            end
        end
    end

    // Next-state: mode, boot counter, PC and latency counter
    always_comb begin
        mode_d     = mode;
        boot_cnt_d = boot_cnt;
        pc_d       = pc;
        lat_d      = lat;
        case (mode)
            MODE_BOOT: begin
                if (boot_cnt >= BOOT_W'(BOOT_STALL)) begin
                    mode_d = MODE_LOAD;
                end else begin
                    boot_cnt_d = boot_cnt + BOOT_W'(1);
                end
            end
            MODE_LOAD: begin
                if (load_done && aa_sent) begin
                    mode_d = MODE_EXEC;
                    lat_d  = '0;
                end
            end
            MODE_EXEC: begin
                if (redirect) begin
                    pc_d  = redirect_pc;
                    lat_d = '0;
                end else if (advance) begin
                    pc_d  = pc + XLEN'(4);
                    lat_d = '0;
                end else if (npc_stall) begin
                    pc_d  = dec_npc;
                    lat_d = lat + LAT_W'(1);
                end else if ((lat < LAT_MAX) && (lat < wait_time)) begin
                    lat_d = lat + LAT_W'(1);
                end
                // A halt still lets this cycle's PC update land
                if (stop_req) begin
                    mode_d = MODE_STOP;
                end
            end
            MODE_STOP: begin
                if (resume) begin
                    mode_d = MODE_EXEC;
                    lat_d  = '0;
                end
            end
            default: begin
                mode_d = MODE_BOOT;
            end
        endcase
        exec_start_d = advance && (mode_d == MODE_EXEC);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode       <= MODE_BOOT;
            boot_cnt   <= '0;
            pc         <= RESET_PC;
            lat        <= '0;
            exec_start <= 1'b0;
        end else begin
            mode       <= mode_d;
            boot_cnt   <= boot_cnt_d;
            pc         <= pc_d;
            lat        <= lat_d;
            exec_start <= exec_start_d;
        end
    end

`ifdef PIPE_SEQ_PERF_EN
    // Free-running EXEC stall and flush counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else if (mode == MODE_EXEC) begin
            if (redirect) begin
                perf_flush <= perf_flush + 32'd1;
            end else if (!advance) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_sequencer;

    localparam int unsigned     XLEN        = 32;
    localparam int unsigned     NSTAGE      = 4;
    localparam int unsigned     FLUSH_DEPTH = 2;
    localparam int unsigned     LAT_W       = 5;
    localparam int unsigned     BOOT_STALL  = 4;
    localparam logic [XLEN-1:0] RESET_PC    = '0;

    logic                clk;
    logic                rstn;
    logic                load_done;
    logic                aa_sent;
    logic [LAT_W-1:0]    wait_time;
    logic                busy;
    logic                jump_dec;
    logic [XLEN-1:0]     dec_npc;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;
    logic                stop_req;
    logic                resume;
    logic [XLEN-1:0]     pc;
    logic [1:0]          mode;
    logic [2*NSTAGE-1:0] stage_update;
    logic                advance;
    logic                exec_start;
    logic [LAT_W-1:0]    lat;
`ifdef PIPE_SEQ_PERF_EN
    logic [31:0]         perf_stall;
    logic [31:0]         perf_flush;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int                  m_mode;
    int                  m_boot;
    int                  m_lat;
    logic [XLEN-1:0]     m_pc;
    bit                  m_es;
    bit                  e_adv;
    logic [2*NSTAGE-1:0] e_su;
`ifdef PIPE_SEQ_PERF_EN
    logic [31:0]         m_pstall;
    logic [31:0]         m_pflush;
`endif

    pipe_sequencer #(
        .XLEN(XLEN), .NSTAGE(NSTAGE), .FLUSH_DEPTH(FLUSH_DEPTH),
        .LAT_W(LAT_W), .BOOT_STALL(BOOT_STALL), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rstn(rstn), .load_done(load_done), .aa_sent(aa_sent),
        .wait_time(wait_time), .busy(busy), .jump_dec(jump_dec), .dec_npc(dec_npc),
        .redirect(redirect), .redirect_pc(redirect_pc), .stop_req(stop_req),
        .resume(resume), .pc(pc), .mode(mode), .stage_update(stage_update),
        .advance(advance), .exec_start(exec_start), .lat(lat)
`ifdef PIPE_SEQ_PERF_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        m_mode = 0; m_boot = 0; m_lat = 0; m_pc = RESET_PC; m_es = 1'b0;
`ifdef PIPE_SEQ_PERF_EN
        m_pstall = 0; m_pflush = 0;
`endif
    endfunction

    // Expected combinational outputs for the current inputs
    function automatic void model_comb();
        bit exec = (m_mode == 2);
        bit fetch_wait = jump_dec && (m_lat == 0);
        e_adv = exec && !redirect && (m_lat >= int'(wait_time)) && !busy && !fetch_wait;
        for (int i = 0; i < NSTAGE; i++) begin
            if (!exec)            e_su[2*i +: 2] = 2'b10;
            else if (redirect)    e_su[2*i +: 2] = (i < FLUSH_DEPTH) ? 2'b10 : 2'b00;
            else if (e_adv)       e_su[2*i +: 2] = 2'b01;
            else                  e_su[2*i +: 2] = 2'b00;
        end
    endfunction

    function automatic void model_clock();
        int nm = m_mode;
        case (m_mode)
            0: if (m_boot >= BOOT_STALL) nm = 1; else m_boot++;
            1: if (load_done && aa_sent) begin nm = 2; m_lat = 0; end
            2: begin
`ifdef PIPE_SEQ_PERF_EN
                if (redirect) m_pflush++; else if (!e_adv) m_pstall++;
`endif
                if (redirect) begin m_pc = redirect_pc; m_lat = 0; end
                else if (e_adv) begin m_pc = m_pc + 32'd4; m_lat = 0; end
                else if (jump_dec && m_lat == 0) begin m_pc = dec_npc; m_lat = 1; end
                else if (m_lat < int'(wait_time)) m_lat++;
                if (stop_req) nm = 3;
            end
            default: if (resume) begin nm = 2; m_lat = 0; end
        endcase
        m_es = e_adv && (nm == 2);
        m_mode = nm;
    endfunction

    task automatic drive(input bit jd, input logic [XLEN-1:0] npc, input bit rd,
                         input logic [XLEN-1:0] rpc, input bit sr, input bit rs,
                         input logic [LAT_W-1:0] wt, input bit bz);
        @(negedge clk);
        jump_dec = jd; dec_npc = npc; redirect = rd; redirect_pc = rpc;
        stop_req = sr; resume = rs; wait_time = wt; busy = bz;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks += 6;
        if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
        if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        if (lat !== '0) begin errors++; $display("FAIL reset_lat: got %0d expected 0", lat); end
        if (exec_start !== 1'b0) begin errors++; $display("FAIL reset_exec_start: got %b expected 0", exec_start); end
        if (stage_update !== 8'hAA) begin errors++; $display("FAIL reset_stage_update: got %h expected aa", stage_update); end
        if (advance !== 1'b0) begin errors++; $display("FAIL reset_advance: got %b expected 0", advance); end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_boot();
        // stop_req/resume toggled during boot must be ignored
        for (int k = 1; k <= BOOT_STALL + 1; k++) begin
            drive(1'b0, '0, 1'b0, '0, k[0], !k[0], '0, 1'b0);
            checks++;
            if (stage_update !== 8'hAA) begin errors++; $display("FAIL boot_stage_update: got %h expected aa", stage_update); end
            tick();
            checks++;
            if (mode !== ((k > BOOT_STALL) ? 2'd1 : 2'd0))
                begin errors++; $display("FAIL boot_mode k=%0d: got %0d expected %0d", k, mode, (k > BOOT_STALL) ? 1 : 0); end
        end
        load_done = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        checks++;
        if (mode !== 2'd1) begin errors++; $display("FAIL load_wait_aa: got %0d expected 1", mode); end
        aa_sent = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        checks += 2;
        if (stage_update !== 8'hAA) begin errors++; $display("FAIL load_stage_update: got %h expected aa", stage_update); end
        if (advance !== 1'b0) begin errors++; $display("FAIL load_advance: got %b expected 0", advance); end
        tick();
        checks += 2;
        if (mode !== 2'd2) begin errors++; $display("FAIL load_to_exec: got %0d expected 2", mode); end
        if (pc !== 32'h0) begin errors++; $display("FAIL exec_entry_pc: got %h expected 0", pc); end
    endtask

    task automatic test_advance();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            checks += 2;
            if (advance !== 1'b1) begin errors++; $display("FAIL adv_advance k=%0d: got %b expected 1", k, advance); end
            if (stage_update !== 8'h55) begin errors++; $display("FAIL adv_stage_update k=%0d: got %h expected 55", k, stage_update); end
            tick();
            checks += 2;
            if (pc !== 32'(4 * k)) begin errors++; $display("FAIL adv_pc k=%0d: got %h expected %h", k, pc, 32'(4 * k)); end
            if (exec_start !== 1'b1) begin errors++; $display("FAIL adv_exec_start k=%0d: got %b expected 1", k, exec_start); end
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checks += 2;
        if (advance !== 1'b0) begin errors++; $display("FAIL busy_advance: got %b expected 0", advance); end
        if (stage_update !== 8'h00) begin errors++; $display("FAIL busy_stage_update: got %h expected 00", stage_update); end
        tick();
        checks += 2;
        if (pc !== 32'hC) begin errors++; $display("FAIL busy_pc: got %h expected c", pc); end
        if (exec_start !== 1'b0) begin errors++; $display("FAIL busy_exec_start: got %b expected 0", exec_start); end
    endtask

    task automatic test_latency();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 5'd3, 1'b0);
            checks++;
            if (advance !== (k == 3)) begin errors++; $display("FAIL lat3_advance k=%0d: got %b expected %b", k, advance, k == 3); end
            tick();
            checks++;
            if (lat !== ((k == 3) ? 5'd0 : 5'(k + 1))) begin errors++; $display("FAIL lat3_lat k=%0d: got %0d expected %0d", k, lat, (k == 3) ? 0 : k + 1); end
        end
        checks++;
        if (pc !== 32'h10) begin errors++; $display("FAIL lat3_pc: got %h expected 10", pc); end
    endtask

    task automatic test_jump();
        drive(1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        checks += 2;
        if (advance !== 1'b0) begin errors++; $display("FAIL jump_advance: got %b expected 0", advance); end
        if (stage_update !== 8'h00) begin errors++; $display("FAIL jump_stage_update: got %h expected 00", stage_update); end
        tick();
        checks += 2;
        if (pc !== 32'h40) begin errors++; $display("FAIL jump_pc: got %h expected 40", pc); end
        if (lat !== 5'd1) begin errors++; $display("FAIL jump_lat: got %0d expected 1", lat); end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (advance !== 1'b1) begin errors++; $display("FAIL jump_next_advance: got %b expected 1", advance); end
        tick();
        checks++;
        if (pc !== 32'h44) begin errors++; $display("FAIL jump_next_pc: got %h expected 44", pc); end
    endtask

    task automatic test_redirect();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 5'd2, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 32'h100, 1'b0, 1'b0, 5'd2, 1'b0);
        checks += 2;
        if (stage_update !== 8'b00_00_10_10) begin errors++; $display("FAIL redirect_stage_update: got %h expected 0a", stage_update); end
        if (advance !== 1'b0) begin errors++; $display("FAIL redirect_advance: got %b expected 0", advance); end
        tick();
        checks += 2;
        if (pc !== 32'h100) begin errors++; $display("FAIL redirect_pc: got %h expected 100", pc); end
        if (lat !== 5'd0) begin errors++; $display("FAIL redirect_lat: got %0d expected 0", lat); end
    endtask

    task automatic test_stop();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 5'd2, 1'b0);
        tick();
        checks += 2;
        if (mode !== 2'd3) begin errors++; $display("FAIL stop_mode: got %0d expected 3", mode); end
        if (lat !== 5'd1) begin errors++; $display("FAIL stop_lat: got %0d expected 1", lat); end
        for (int k = 0; k < 10; k++) begin
            drive(1'($urandom_range(1)), $urandom, 1'b0, '0, 1'($urandom_range(1)), 1'b0, '0, 1'b0);
            checks += 2;
            if (stage_update !== 8'hAA) begin errors++; $display("FAIL stop_stage_update k=%0d: got %h expected aa", k, stage_update); end
            if (advance !== 1'b0) begin errors++; $display("FAIL stop_advance k=%0d: got %b expected 0", k, advance); end
            tick();
            checks++;
            if (pc !== 32'h100) begin errors++; $display("FAIL stop_pc_hold k=%0d: got %h expected 100", k, pc); end
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
        tick();
        checks += 2;
        if (mode !== 2'd2) begin errors++; $display("FAIL resume_mode: got %0d expected 2", mode); end
        if (lat !== 5'd0) begin errors++; $display("FAIL resume_lat: got %0d expected 0", lat); end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (advance !== 1'b1) begin errors++; $display("FAIL resume_advance: got %b expected 1", advance); end
        tick();
        checks += 2;
        if (pc !== 32'h104) begin errors++; $display("FAIL resume_pc: got %h expected 104", pc); end
        if (mode !== 2'd2) begin errors++; $display("FAIL resume_ignored_in_exec: got %0d expected 2", mode); end
        // Halt together with redirect: redirect lands, mode stops
        drive(1'b0, '0, 1'b1, 32'h200, 1'b1, 1'b0, '0, 1'b0);
        tick();
        checks += 2;
        if (pc !== 32'h200) begin errors++; $display("FAIL stop_redirect_pc: got %h expected 200", pc); end
        if (mode !== 2'd3) begin errors++; $display("FAIL stop_redirect_mode: got %0d expected 3", mode); end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
        tick();
        // Halt on an advancing cycle: PC moves but no start strobe into STOP
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        checks += 2;
        if (pc !== 32'h204) begin errors++; $display("FAIL stop_adv_pc: got %h expected 204", pc); end
        if (exec_start !== 1'b0) begin errors++; $display("FAIL stop_exec_start: got %b expected 0", exec_start); end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [LAT_W-1:0] wt;
        for (int n = 0; n < 400; n++) begin
            wt = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(3));
            drive($urandom_range(3) == 0, $urandom, $urandom_range(7) == 0, $urandom,
                  $urandom_range(15) == 0, $urandom_range(2) == 0, wt, $urandom_range(3) == 0);
            checks += 2;
            if (advance !== e_adv) begin errors++; $display("FAIL rand_advance n=%0d: got %b expected %b", n, advance, e_adv); end
            if (stage_update !== e_su) begin errors++; $display("FAIL rand_stage_update n=%0d: got %h expected %h", n, stage_update, e_su); end
            tick();
            checks += 4;
            if (pc !== m_pc) begin errors++; $display("FAIL rand_pc n=%0d: got %h expected %h", n, pc, m_pc); end
            if (mode !== 2'(m_mode)) begin errors++; $display("FAIL rand_mode n=%0d: got %0d expected %0d", n, mode, m_mode); end
            if (lat !== 5'(m_lat)) begin errors++; $display("FAIL rand_lat n=%0d: got %0d expected %0d", n, lat, m_lat); end
            if (exec_start !== m_es) begin errors++; $display("FAIL rand_exec_start n=%0d: got %b expected %b", n, exec_start, m_es); end
`ifdef PIPE_SEQ_PERF_EN
            checks += 2;
            if (perf_stall !== m_pstall) begin errors++; $display("FAIL rand_perf_stall n=%0d: got %0d expected %0d", n, perf_stall, m_pstall); end
            if (perf_flush !== m_pflush) begin errors++; $display("FAIL rand_perf_flush n=%0d: got %0d expected %0d", n, perf_flush, m_pflush); end
`endif
        end
    endtask

    task automatic test_reset_mid_exec();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 5'd3, 1'b0);
        tick();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        checks += 5;
        if (pc !== RESET_PC) begin errors++; $display("FAIL midrst_pc: got %h expected %h", pc, RESET_PC); end
        if (mode !== 2'd0) begin errors++; $display("FAIL midrst_mode: got %0d expected 0", mode); end
        if (lat !== '0) begin errors++; $display("FAIL midrst_lat: got %0d expected 0", lat); end
        if (stage_update !== 8'hAA) begin errors++; $display("FAIL midrst_stage_update: got %h expected aa", stage_update); end
        if (advance !== 1'b0) begin errors++; $display("FAIL midrst_advance: got %b expected 0", advance); end
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int k = 1; k <= BOOT_STALL + 1; k++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            tick();
            checks++;
            if (mode !== ((k > BOOT_STALL) ? 2'd1 : 2'd0))
                begin errors++; $display("FAIL midrst_boot k=%0d: got %0d expected %0d", k, mode, (k > BOOT_STALL) ? 1 : 0); end
        end
    endtask

    initial begin
        rstn = 1'b0; load_done = 1'b0; aa_sent = 1'b0; wait_time = '0; busy = 1'b0;
        jump_dec = 1'b0; dec_npc = '0; redirect = 1'b0; redirect_pc = '0;
        stop_req = 1'b0; resume = 1'b0;
        model_reset();
        test_reset();
        test_boot();
        test_advance();
        test_latency();
        test_jump();
        test_redirect();
        test_stop();
        test_random();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Central pipeline controller for the multi-cycle CPU core, replacing the hard-wired three-register stall/flush logic in the top level. It owns the boot/load/exec/stop mode machine, the fetch PC, and the execute-latency counter. It emits one hold/advance/flush code per pipeline register for any pipeline depth, with configurable partial flush on redirect and restart from STOP.

## Interface
Parameters:
- XLEN, 32, PC/data width
- NSTAGE, 3, number of inter-stage pipeline registers (index 0 = youngest, fetch/decode)
- FLUSH_DEPTH, NSTAGE, youngest registers cleared on redirect (1..NSTAGE); older ones hold
- LAT_W, 5, latency counter / wait_time width
- BOOT_STALL, 10000, cycles spent in BOOT before LOAD
- RESET_PC, 0, PC after reset

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- load_done  in  1  program loader finished
- aa_sent  in  1  host handshake byte transmitted
- wait_time  in  LAT_W  extra cycles the instruction in execute needs
- busy  in  1  execute-side unit (UART) busy
- jump_dec  in  1  decode holds a jump whose target is dec_npc
- dec_npc  in  XLEN  decode-computed next PC
- redirect  in  1  writeback detected mispredicted PC
- redirect_pc  in  XLEN  corrected PC
- stop_req  in  1  halt instruction in execute
- resume  in  1  leave STOP
- pc  out  XLEN  fetch PC
- mode  out  2  BOOT=0, LOAD=1, EXEC=2, STOP=3
- stage_update  out  2*NSTAGE  per-register code, bits [2i+1:2i] for register i: 00 hold, 01 advance, 10 clear
- advance  out  1  pipeline advances this cycle
- exec_start  out  1  registered advance, one-cycle start strobe to execute
- lat  out  LAT_W  current latency count

## Operation
- Mode FSM: BOOT counts boot_cnt each cycle; when boot_cnt >= BOOT_STALL → LOAD. LOAD: load_done && aa_sent → EXEC. EXEC: stop_req → STOP. STOP: resume → EXEC.
- npc_stall = jump_dec && lat==0. advance = mode==EXEC && !redirect && lat>=wait_time && !busy && !npc_stall.
- stage_update: mode!=EXEC → all 10. EXEC with redirect → registers 0..FLUSH_DEPTH-1 = 10, rest = 00. Else advance → all 01. Else all 00.
- PC/lat in EXEC, priority order: redirect → pc<=redirect_pc, lat<=0; advance → pc<=pc+4 (mod 2^XLEN), lat<=0; npc_stall → pc<=dec_npc, lat<=lat+1; else lat<lat_max and lat<wait_time → lat<=lat+1.
- lat saturates at 2^LAT_W-1; never wraps.
- Outside EXEC, pc and lat hold (lat forced 0 on entry to EXEC from LOAD or STOP).
- stop_req and redirect together: PC redirect still applied; mode → STOP.
- resume outside STOP ignored; stop_req outside EXEC ignored.

## Timing
- Reset (async): pc=RESET_PC, mode=BOOT, boot_cnt=0, lat=0, exec_start=0; stage_update = all 10, advance=0 (combinational from mode).
- stage_update and advance combinational from current-cycle inputs and state; pc, lat, mode, exec_start update on clk rising edge.
- exec_start = advance delayed one cycle; forced 0 outside EXEC.
- Instruction with wait_time=N and busy=0 advances after N+1 cycles in execute.
- LOAD→EXEC first fetch uses pc unchanged.
- Reset asserted mid-EXEC: all state returns to reset values immediately; BOOT restarts from 0.

## Configuration
- PIPE_SEQ_PERF_EN defined: adds outputs perf_stall (32-bit, counts EXEC cycles with advance=0 and no redirect) and perf_flush (32-bit, counts redirect cycles in EXEC); both reset to 0 and wrap at 2^32.
- Undefined: counters and ports absent; all other behaviour identical.

## Test plan
- Boot with BOOT_STALL=4: mode BOOT until cycle 5, LOAD; load_done=aa_sent=1 → EXEC next edge, pc=0, stage_update=all 10 before EXEC.
- EXEC, wait_time=0, busy=0: pc 0→4→8 each cycle, stage_update all 01, exec_start trails advance by 1.
- wait_time=3: advance high only on 4th cycle, lat 0,1,2,3 then 0, pc +4 once.
- jump_dec=1, dec_npc=0x40 at lat=0: one stall cycle, pc=0x40, then normal advance.
- NSTAGE=4, FLUSH_DEPTH=2, redirect with redirect_pc=0x100 while wait_time=2: stage_update=00_00_10_10, pc=0x100, lat=0.
- stop_req in EXEC → STOP, pc holds 10 cycles; resume → EXEC, lat=0, advance resumes.
